divider: RTL and testbench

- Multi-cycle radix-2 restoring integer divider. It is the inverse-operation companion to the Booth multiplier in the RV32M execute stage.
- Serves DIV/DIVU/REM/REMU.
- Uses the same start/stall/finish handshake as the multiplier, so the pipeline control logic treats both units identically.
- Produces RISC-V-compliant results, including the divide-by-zero and signed-overflow cases.

---
 rtl/divider.sv | 141 ++++++++++++++
 tb/tb_divider.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V special-case results.
// Optional DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            signed_op,
  input  logic            start,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            stall,
  output logic            finish
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state, state_nx;
  logic [CNT_W-1:0]    counter;
  logic [2*XLEN-1:0]   work, work_nx;
  logic [XLEN-1:0]     dvsr, dividend_q;
  logic                neg_q, neg_r, div0, ovf;
  logic [XLEN-1:0]     dividend_abs, divisor_abs;
  logic                div0_in, ovf_in, last_iter;
  logic [XLEN:0]       partial, diff;
  logic [XLEN-1:0]     q_fix, r_fix;

  always_comb begin
    dividend_abs = (signed_op & dividend[XLEN-1]) ? -dividend : dividend;
    divisor_abs  = (signed_op & divisor[XLEN-1])  ? -divisor  : divisor;
    div0_in      = (divisor == {XLEN{1'b0}});
    ovf_in       = signed_op & (dividend == MIN_NEG) & (divisor == {XLEN{1'b1}});
    last_iter    = (counter == CNT_W'(XLEN-1));
  end

  // The partial remainder includes the bit shifted out of the upper half,
  // so the subtraction never loses a carry when the divisor is >= 2^(XLEN-1).
  always_comb begin
    partial = work[2*XLEN-1:XLEN-1];
    diff    = partial - {1'b0, dvsr};
    if (diff[XLEN]) work_nx = {partial[XLEN-1:0], work[XLEN-2:0], 1'b0};
    else            work_nx = {diff[XLEN-1:0],    work[XLEN-2:0], 1'b1};
  end

  always_comb begin
    if (div0) begin
      q_fix = {XLEN{1'b1}};
      r_fix = dividend_q;
    end else if (ovf) begin
      q_fix = MIN_NEG;
      r_fix = {XLEN{1'b0}};
    end else begin
      q_fix = neg_q ? -work_nx[XLEN-1:0]      : work_nx[XLEN-1:0];
      r_fix = neg_r ? -work_nx[2*XLEN-1:XLEN] : work_nx[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
`ifdef DIVIDER_EARLY_OUT_EN
          state_nx = (div0_in | ovf_in) ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (last_iter) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      work       <= '0;
      dvsr       <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div0       <= 1'b0;
      ovf        <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      finish     <= 1'b0;
    end else begin
      finish <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            work       <= {{XLEN{1'b0}}, dividend_abs};
            dvsr       <= divisor_abs;
            dividend_q <= dividend;
            neg_q      <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r      <= signed_op & dividend[XLEN-1];
            div0       <= div0_in;
            ovf        <= ovf_in;
            counter    <= '0;
`ifdef DIVIDER_EARLY_OUT_EN
            if (div0_in) begin
              quotient  <= {XLEN{1'b1}};
              remainder <= dividend;
            end else if (ovf_in) begin
              quotient  <= MIN_NEG;
              remainder <= {XLEN{1'b0}};
            end
`endif
          end
        end
        BUSY: begin
          work    <= work_nx;
          counter <= counter + 1'b1;
          if (last_iter) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed RISC-V cases, randomized ops against an arithmetic model,
// asynchronous reset mid-operation and back-to-back starts.
module tb_divider;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] dividend, divisor;
  logic            signed_op, start;
  logic [XLEN-1:0] quotient, remainder;
  logic            stall, finish;

  int checks = 0;
  int passed = 0;
  logic [XLEN-1:0] exp_q[$];

  divider #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .dividend(dividend), .divisor(divisor),
    .signed_op(signed_op), .start(start), .quotient(quotient),
    .remainder(remainder), .stall(stall), .finish(finish)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // reference model: plain arithmetic plus the RISC-V special cases
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 32'd0;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // driver: one operation with start pulsed for a single cycle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] q_e, input logic [31:0] r_e, input string name);
    int   lat_e, n;
    bit   seen, stall_ok;
    logic [31:0] q_x, r_x;
    exp_q.push_back(q_e);
    exp_q.push_back(r_e);
    lat_e = (EARLY && (b == 32'd0 || (s && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : XLEN + 1;
    @(posedge clk); #1;
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) $display("FAIL %s accept_stall got %b want 1", name, stall);
    else passed++;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom_range(0, 1));
    seen = 0; stall_ok = 1; n = 0;
    while (!seen && n < XLEN + 8) begin
      @(negedge clk);
      n++;
      if (finish === 1'b1) seen = 1;
      else if (stall !== 1'b1) stall_ok = 0;
    end
    checks++;
    if (!seen || n != lat_e) $display("FAIL %s latency got %0d (seen=%0d) want %0d", name, n, seen, lat_e);
    else passed++;
    checks++;
    if (!stall_ok) $display("FAIL %s busy_stall got low want high while busy", name);
    else passed++;
    q_x = exp_q.pop_front();
    r_x = exp_q.pop_front();
    if (seen) begin
      checks++;
      if (stall !== 1'b0) $display("FAIL %s done_stall got %b want 0", name, stall);
      else passed++;
      checks++;
      if (quotient !== q_x) $display("FAIL %s quotient got %h want %h", name, quotient, q_x);
      else passed++;
      checks++;
      if (remainder !== r_x) $display("FAIL %s remainder got %h want %h", name, remainder, r_x);
      else passed++;
      @(negedge clk);
      checks++;
      if (finish !== 1'b0 || quotient !== q_x || remainder !== r_x)
        $display("FAIL %s pulse_hold got fin=%b q=%h r=%h want fin=0 q=%h r=%h",
                 name, finish, quotient, remainder, q_x, r_x);
      else passed++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (quotient !== 32'd0) $display("FAIL reset_quotient got %h want 0", quotient);
    else passed++;
    checks++;
    if (remainder !== 32'd0) $display("FAIL reset_remainder got %h want 0", remainder);
    else passed++;
    checks++;
    if (finish !== 1'b0) $display("FAIL reset_finish got %b want 0", finish);
    else passed++;
    checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "u100_7");
    run_op(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   "s-7_2");
    run_op(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          "s7_-2");
    run_op(32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234,   "u_div0");
    run_op(32'h00001234,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h00001234,   "s_div0");
    run_op(32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9,   "s_neg_div0");
    run_op(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          "s_ovf");
    run_op(32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   "u_ovf_ops");
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic        s;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        3: b = $urandom >> $urandom_range(0, 31);
        default: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd0; end
      endcase
      model(a, b, s, q, r);
      run_op(a, b, s, q, r, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit fin_seen;
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "pre_reset");
    @(posedge clk); #1;
    dividend = 32'd12345; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0)
      $display("FAIL midreset_results got q=%h r=%h want 0 0", quotient, remainder);
    else passed++;
    checks++;
    if (finish !== 1'b0 || stall !== 1'b0)
      $display("FAIL midreset_ctrl got fin=%b stall=%b want 0 0", finish, stall);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    fin_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (finish !== 1'b0 || stall !== 1'b0) fin_seen = 1;
    end
    checks++;
    if (fin_seen) $display("FAIL midreset_no_finish got activity after reset want idle");
    else passed++;
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int   p1, p2, extra;
    bit   width_ok, hold_ok, prev_fin;
    logic [31:0] q1, r1, q2, r2;
    p1 = -1; p2 = -1; extra = 0; width_ok = 1; hold_ok = 1; prev_fin = 0;
    q1 = 0; r1 = 0; q2 = 0; r2 = 0;
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd9; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd0 - 32'd1000; divisor = 32'd9; signed_op = 1'b1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge clk);
      if (finish === 1'b1) begin
        if (prev_fin) width_ok = 0;
        else if (p1 < 0) begin
          p1 = cyc; q1 = quotient; r1 = remainder;
        end else if (p2 < 0) begin
          p2 = cyc; q2 = quotient; r2 = remainder; start = 1'b0;
        end else extra++;
      end else if (p1 >= 0 && p2 < 0) begin
        if (quotient !== q1 || remainder !== r1) hold_ok = 0;
      end
      prev_fin = finish;
    end
    start = 1'b0;
    checks++;
    if (p1 != XLEN + 1) $display("FAIL b2b_first_finish got %0d want %0d", p1, XLEN + 1);
    else passed++;
    checks++;
    if (p2 < 0 || p2 - p1 != XLEN + 2) $display("FAIL b2b_spacing got %0d want %0d", p2 - p1, XLEN + 2);
    else passed++;
    checks++;
    if (!width_ok || extra != 0) $display("FAIL b2b_pulse got width_ok=%0d extra=%0d want 1 0", width_ok, extra);
    else passed++;
    checks++;
    if (!hold_ok) $display("FAIL b2b_hold got changing outputs want stable between pulses");
    else passed++;
    checks++;
    if (q1 !== 32'd111 || r1 !== 32'd1) $display("FAIL b2b_op1 got q=%h r=%h want 6f 1", q1, r1);
    else passed++;
    checks++;
    if (q2 !== 32'hFFFFFF91 || r2 !== 32'hFFFFFFFF)
      $display("FAIL b2b_op2 got q=%h r=%h want ffffff91 ffffffff", q2, r2);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; signed_op = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
